// File: rtl/nibble_pkg.sv
// Shared constants and types for the nibble deserializer front end.
package nibble_pkg;
   localparam int NIBBLE_W     = 4;
   localparam int NIBBLE_CNT_W = 3;
   typedef logic [NIBBLE_W-1:0] nibble_t;
endpackage

// File: rtl/nibble_shift_reg.sv
// MSB-first shift register with bit counter and sync restart; strobes o_done
// in the cycle the final frame bit is sampled, with the full frame on o_frame.
module nibble_shift_reg
   import nibble_pkg::*;
#(
   parameter int FRAME_W = NIBBLE_W
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_sin,
   input  logic               i_sin_valid,
   input  logic               i_sync,
   output logic               o_done,
   output logic [FRAME_W-1:0] o_frame,
   output logic               o_busy
);
   localparam logic [NIBBLE_CNT_W-1:0] LAST = NIBBLE_CNT_W'(FRAME_W - 1);

   logic [FRAME_W-1:0]      r_sr;
   logic [NIBBLE_CNT_W-1:0] r_cnt;
   logic [FRAME_W-1:0]      w_sr;
   logic [NIBBLE_CNT_W-1:0] w_cnt;
   logic [FRAME_W-1:0]      w_next_sr;
   logic                    w_done;

   // sync makes the bit sampled in the same cycle bit 0 of a fresh frame
   assign w_cnt     = i_sync ? '0 : r_cnt;
   assign w_sr      = i_sync ? '0 : r_sr;
   assign w_next_sr = {w_sr[FRAME_W-2:0], i_sin};
   assign w_done    = i_sin_valid && (w_cnt == LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else if (i_sin_valid) begin
         r_sr  <= w_next_sr;
         r_cnt <= w_done ? '0 : w_cnt + 1'b1;
      end else if (i_sync) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end
   end

   assign o_done  = w_done;
   assign o_frame = w_next_sr;
   assign o_busy  = (r_cnt != '0);
endmodule

// File: rtl/nibble_deserializer.sv
// Serial-to-parallel nibble front end with one-entry output register and
// sticky overflow. Define NIBBLE_DES_PARITY_EN for a trailing odd-parity bit.
module nibble_deserializer
   import nibble_pkg::*;
#(
   parameter int W = NIBBLE_W
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_sin,
   input  logic         i_sin_valid,
   input  logic         i_sync,
   output logic [W-1:0] o_word,
   output logic         o_word_valid,
   input  logic         i_word_ready,
   output logic         o_busy,
   output logic         o_overflow,
   output logic         o_parity_err
);
`ifdef NIBBLE_DES_PARITY_EN
   localparam int FRAME_W = W + 1;
`else
   localparam int FRAME_W = W;
`endif

   logic               w_done;
   logic [FRAME_W-1:0] w_frame;
   logic [W-1:0]       w_word;
   logic               w_par_ok;
   logic               w_accept;
   logic               w_load;
   logic               w_drop;
   logic [W-1:0]       r_word;
   logic               r_valid;
   logic               r_ovf;

   nibble_shift_reg #(.FRAME_W(FRAME_W)) u_sr (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_sin       (i_sin),
      .i_sin_valid (i_sin_valid),
      .i_sync      (i_sync),
      .o_done      (w_done),
      .o_frame     (w_frame),
      .o_busy      (o_busy)
   );

   assign w_word = w_frame[FRAME_W-1 -: W];

`ifdef NIBBLE_DES_PARITY_EN
   logic r_perr;
   assign w_par_ok = ^w_frame;
   always_ff @(posedge i_clk) begin
      if (i_rst) r_perr <= 1'b0;
      else       r_perr <= w_done & ~w_par_ok;
   end
   assign o_parity_err = r_perr;
`else
   assign w_par_ok     = 1'b1;
   assign o_parity_err = 1'b0;
`endif

   // a word failing parity is neither loaded nor counted as overflow
   assign w_accept = w_done & w_par_ok;
   assign w_load   = w_accept & (~r_valid | i_word_ready);
   assign w_drop   = w_accept & r_valid & ~i_word_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_word  <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_load) r_word <= w_word;
         r_valid <= w_load | (r_valid & ~i_word_ready);
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   assign o_word       = r_word;
   assign o_word_valid = r_valid;
   assign o_overflow   = r_ovf;
endmodule

// File: tb/tb_nibble_deserializer.sv
// Directed bench for nibble_deserializer; covers parity frames when
// NIBBLE_DES_PARITY_EN is defined.
module tb_nibble_deserializer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sin = 1'b0;
   logic       sin_valid = 1'b0;
   logic       sync = 1'b0;
   logic       word_ready = 1'b0;
   logic [3:0] word;
   logic       word_valid, busy, overflow, parity_err;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   nibble_deserializer dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_sin        (sin),
      .i_sin_valid  (sin_valid),
      .i_sync       (sync),
      .o_word       (word),
      .o_word_valid (word_valid),
      .i_word_ready (word_ready),
      .o_busy       (busy),
      .o_overflow   (overflow),
      .o_parity_err (parity_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic rdy);
      sin        = b;
      sin_valid  = 1'b1;
      word_ready = rdy;
      tick();
      sin_valid  = 1'b0;
   endtask

   // data bits MSB first, plus odd parity bit in the parity build;
   // rdy_last applies to the final bit of the frame
   task automatic send_frame(input logic [3:0] w, input logic rdy_body, input logic rdy_last);
`ifdef NIBBLE_DES_PARITY_EN
      for (int i = 3; i >= 0; i--) send_bit(w[i], rdy_body);
      send_bit(~^w, rdy_last);
`else
      for (int i = 3; i >= 1; i--) send_bit(w[i], rdy_body);
      send_bit(w[0], rdy_last);
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1; sin_valid = 1'b0; sync = 1'b0; word_ready = 1'b0; sin = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({word, word_valid, busy, overflow, parity_err} !== 8'h00) begin
         bad++;
         $display("FAIL reset: word=%b valid=%b busy=%b ovf=%b perr=%b, required all 0",
                  word, word_valid, busy, overflow, parity_err);
      end
   endtask

   task automatic test_basic();
      do_reset();
      send_bit(1'b1, 1'b1);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: busy=%b required 1", busy); end
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b1);
`ifdef NIBBLE_DES_PARITY_EN
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b1);
`else
      send_bit(1'b0, 1'b1);
`endif
      total++;
      if (word_valid !== 1'b1 || word !== 4'b1010) begin
         bad++; $display("FAIL basic_word: valid=%b word=%b required 1 1010", word_valid, word);
      end
      total++;
      if (busy !== 1'b0 || parity_err !== 1'b0) begin
         bad++; $display("FAIL basic_flags: busy=%b perr=%b required 0 0", busy, parity_err);
      end
      tick();
      total++;
      if (word_valid !== 1'b0 || word !== 4'b1010) begin
         bad++; $display("FAIL basic_consume: valid=%b word=%b required 0 1010", word_valid, word);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_frame(4'b1110, 1'b1, 1'b1);
      total++;
      if (word_valid !== 1'b1 || word !== 4'b1110) begin
         bad++; $display("FAIL b2b_first: valid=%b word=%b required 1 1110", word_valid, word);
      end
      send_frame(4'b0001, 1'b1, 1'b1);
      total++;
      if (word_valid !== 1'b1 || word !== 4'b0001 || overflow !== 1'b0) begin
         bad++; $display("FAIL b2b_second: valid=%b word=%b ovf=%b required 1 0001 0",
                         word_valid, word, overflow);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      send_frame(4'b1000, 1'b0, 1'b0);
      total++;
      if (word_valid !== 1'b1 || word !== 4'b1000 || overflow !== 1'b0) begin
         bad++; $display("FAIL ovf_first: valid=%b word=%b ovf=%b required 1 1000 0",
                         word_valid, word, overflow);
      end
      send_frame(4'b0101, 1'b0, 1'b0);
      total++;
      if (word_valid !== 1'b1 || word !== 4'b1000 || overflow !== 1'b1) begin
         bad++; $display("FAIL ovf_drop: valid=%b word=%b ovf=%b required 1 1000 1",
                         word_valid, word, overflow);
      end
      word_ready = 1'b1;
      tick();
      total++;
      if (word_valid !== 1'b0 || overflow !== 1'b1 || word !== 4'b1000) begin
         bad++; $display("FAIL ovf_sticky: valid=%b ovf=%b word=%b required 0 1 1000",
                         word_valid, overflow, word);
      end
   endtask

   task automatic test_sync();
      logic seen;
      seen = 1'b0;
      do_reset();
      send_bit(1'b1, 1'b1); seen |= word_valid;
      send_bit(1'b1, 1'b1); seen |= word_valid;
      sync = 1'b1;
      send_bit(1'b0, 1'b1); seen |= word_valid;
      sync = 1'b0;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL sync_busy: busy=%b required 1", busy); end
      send_bit(1'b0, 1'b1); seen |= word_valid;
      send_bit(1'b1, 1'b1); seen |= word_valid;
`ifdef NIBBLE_DES_PARITY_EN
      send_bit(1'b1, 1'b1); seen |= word_valid;
      send_bit(1'b1, 1'b1);
`else
      send_bit(1'b1, 1'b1);
`endif
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL sync_early: early valid=%b required 0", seen); end
      total++;
      if (word_valid !== 1'b1 || word !== 4'b0011) begin
         bad++; $display("FAIL sync_word: valid=%b word=%b required 1 0011", word_valid, word);
      end
   endtask

   task automatic test_ready_same_cycle();
      do_reset();
      send_frame(4'b0110, 1'b0, 1'b0);
      send_frame(4'b1001, 1'b0, 1'b1);
      total++;
      if (word_valid !== 1'b1 || word !== 4'b1001 || overflow !== 1'b0) begin
         bad++; $display("FAIL same_cycle: valid=%b word=%b ovf=%b required 1 1001 0",
                         word_valid, word, overflow);
      end
   endtask

   task automatic test_reset_midword();
      do_reset();
      send_frame(4'b0111, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (word !== 4'b0000 || word_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
         bad++; $display("FAIL rst_mid: word=%b valid=%b busy=%b ovf=%b required 0000 0 0 0",
                         word, word_valid, busy, overflow);
      end
   endtask

`ifdef NIBBLE_DES_PARITY_EN
   task automatic test_parity();
      do_reset();
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      total++;
      if (word_valid !== 1'b1 || word !== 4'b1010 || parity_err !== 1'b0) begin
         bad++; $display("FAIL par_good: valid=%b word=%b perr=%b required 1 1010 0",
                         word_valid, word, parity_err);
      end
      do_reset();
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      total++;
      if (parity_err !== 1'b1 || word_valid !== 1'b0 || overflow !== 1'b0) begin
         bad++; $display("FAIL par_bad: perr=%b valid=%b ovf=%b required 1 0 0",
                         parity_err, word_valid, overflow);
      end
      tick();
      total++;
      if (parity_err !== 1'b0 || word_valid !== 1'b0) begin
         bad++; $display("FAIL par_pulse: perr=%b valid=%b required 0 0", parity_err, word_valid);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_overflow();
      test_sync();
      test_ready_same_cycle();
      test_reset_midword();
`ifdef NIBBLE_DES_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/nibble_deserializer.md
# nibble_deserializer

Serial-to-parallel front end that assembles a single-bit input stream into 4-bit words, MSB first, and hands each completed word to the downstream nibble-processing stage over a valid/ready handshake. It sits directly upstream of the 4-bit concatenation/split logic and feeds its `a` bus. A one-entry output register decouples bit arrival from downstream acceptance. Overflow and framing-resync support are built in.

## Interface
- `W`, 4, word width in bits; all counts and widths below scale with it.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `sin`  in  1  serial data bit.
- `sin_valid`  in  1  `sin` is sampled this cycle.
- `sync`  in  1  discard any partial word; restart bit count.
- `word`  out  W  assembled word; `word[W-1]` is the first bit received.
- `word_valid`  out  1  `word` holds an unconsumed value.
- `word_ready`  in  1  downstream accepts `word` this cycle.
- `busy`  out  1  partial word in progress (bit count ≠ 0).
- `overflow`  out  1  sticky; a completed word was dropped.
- `parity_err`  out  1  one-cycle pulse; parity check failed.

## Operation
- Reset values: `word`=0, `word_valid`=0, `busy`=0, `overflow`=0, `parity_err`=0, bit count=0, shift register=0.
- States (bit count): IDLE (0) → SHIFT (1..W-1) → complete on the W-th accepted bit.
  - When the parity option is compiled in, a W+1-th bit is required.
- Each cycle with `sin_valid`=1, shift `sin` in at the LSB, MSB-first. The count increments.
- Completion: the assembled word is offered to the output register and the count returns to 0 in the same cycle.
- Output register:
  - Loads the word if `word_valid`=0, or if `word_valid`=1 and `word_ready`=1 in the same cycle (back-to-back; `word_valid` stays 1).
  - Otherwise the new word is dropped, the held word is kept unchanged, and `overflow` sets.
- `word_valid` clears when `word_ready`=1 and no new word loads that cycle.
- `word` holds its value while `word_valid`=0.
- `word_ready` while `word_valid`=0 has no effect.
- `sync`=1: count forced to 0 and partial bits discarded. If `sin_valid`=1 in the same cycle, that bit is taken as bit 0 of a new word. The output register and `overflow` are unaffected.
- `overflow` clears only on `rst`.
- `rst` mid-word: the partial word is lost and the held word is lost; all outputs return to reset values the next cycle.

## Timing
- Latency: `word_valid` rises the cycle after the edge that samples the final bit.
- Minimum word period is W cycles (W+1 with parity). At that rate, with `word_ready` tied high, no words are dropped.
- `busy` is registered: high from the cycle after the first bit until the cycle after completion.
- `parity_err` is high for exactly the one cycle after the failing parity bit is sampled.

## Configuration
- Macro: `NIBBLE_DES_PARITY_EN`.
- Defined:
  - Each frame is W data bits followed by one parity bit.
  - Odd parity across all W+1 bits is required.
  - On a parity failure, the word is discarded (never loaded and never counted as overflow) and `parity_err` pulses.
- Undefined:
  - Frames are W bits.
  - `parity_err` is present and tied 0.

## Structure
- Shared package `nibble_pkg`:
  - `NIBBLE_W` = 4.
  - Counter width constant `NIBBLE_CNT_W` = 3.
  - Typedef `nibble_t` = logic [NIBBLE_W-1:0].
- Sub-module `nibble_shift_reg`: shift register plus bit counter plus `sync` handling. It emits a completion strobe and the assembled word.
- Top level: output register, handshake, overflow logic, and parity logic.

## Test plan
- Shift in 1,0,1,0 on consecutive cycles with `word_ready`=1 → `word`=4'b1010, `word_valid` high one cycle, next cycle after the 4th bit.
- Send 1110, then 0001 back-to-back with `word_ready`=1 → `word` goes 1110 then 0001 four cycles apart, `overflow`=0.
- Send 1000 with `word_ready`=0, then 0101 → `word` stays 1000, `overflow`=1 after the 8th bit. Raise `word_ready` → `word_valid` drops; `overflow` stays 1.
- Send 1,1 then pulse `sync` with `sin_valid`=1 and `sin`=0, then bits 0,1,1 → `word`=4'b0011; the partial 11 never appears.
- Complete a word while `word_valid`=1 and `word_ready`=1 in the same cycle → new word loaded, `word_valid` stays 1, no overflow.
- With `NIBBLE_DES_PARITY_EN`:
  - Send 1010 + parity 1 → `word`=1010.
  - Send 1010 + parity 0 → `parity_err` one-cycle pulse, `word_valid` stays 0.
